// File: rtl/cpu.sv
// cpu: 8-bit accumulator CPU with a shared tri-state memory bus and a T0..T4 micro-step sequencer.
// Optional CPU_CARRY_FLAG_EN adds a carry flag latched by ADD/SUB and a JC (0A) conditional jump.
module cpu #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] addr_bus,
    inout  wire  [7:0] bus,
    output logic       mem_clk,
    output logic       c_ri,
    output logic       c_ro
);
    localparam logic [7:0] OP_LDI = 8'h01, OP_LDA = 8'h02, OP_STA = 8'h03, OP_LDB = 8'h04;
    localparam logic [7:0] OP_ADD = 8'h05, OP_SUB = 8'h06, OP_JMP = 8'h07, OP_JZ  = 8'h08;
    localparam logic [7:0] OP_HLT = 8'h09, OP_JC  = 8'h0A;
    typedef enum logic {RUN, HALT} state_t;
    typedef enum logic [2:0] {T0, T1, T2, T3, T4} cycle_t;
    state_t     r_state, w_state_nx;
    cycle_t     r_cycle, w_cycle_nx;
    logic [7:0] r_pc, r_opcode, r_rega, r_regb, r_mar;
    logic       r_eq_zero, r_c_sub;
    logic [7:0] w_op, w_alu_out;
    logic       w_opnd, w_alu_op, w_mem_op, w_jc_op, w_carry;
    // During T1 the opcode is still on the bus; afterwards it is latched.
    assign w_op      = (r_cycle == T1) ? bus : r_opcode;
    assign w_alu_out = r_c_sub ? r_rega - r_regb : r_rega + r_regb;
    assign w_alu_op  = (w_op == OP_ADD) || (w_op == OP_SUB);
    assign w_mem_op  = w_op inside {OP_LDA, OP_LDB, OP_STA};
    assign w_opnd    = (w_op inside {OP_LDI, OP_LDA, OP_STA, OP_LDB, OP_JMP, OP_JZ}) || w_jc_op;
    assign addr_bus  = r_mar;
    assign mem_clk   = ~clk;
    assign bus       = c_ri ? r_rega : 8'hzz;
`ifdef CPU_CARRY_FLAG_EN
    logic r_carry;
    assign w_jc_op = (w_op == OP_JC);
    assign w_carry = r_carry;
    // ADD carries out when the sum wrapped; SUB is borrow-free when rega >= regb.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_carry <= 1'b0;
        else if (r_state == RUN && r_cycle == T2 && w_alu_op)
            r_carry <= r_c_sub ? (r_rega >= r_regb) : (w_alu_out < r_rega);
    end
`else
    assign w_jc_op = 1'b0;
    assign w_carry = 1'b0;
`endif
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RUN;
            r_cycle <= T0;
        end else begin
            r_state <= w_state_nx;
            r_cycle <= w_cycle_nx;
        end
    end
    always_comb begin
        w_state_nx = r_state;
        w_cycle_nx = T0;
        c_ro       = 1'b0;
        c_ri       = 1'b0;
        if (r_state == RUN) begin
            case (r_cycle)
                T0: w_cycle_nx = T1;
                T1: begin
                    c_ro       = 1'b1;
                    w_cycle_nx = (w_opnd || w_alu_op) ? T2 : T0;
                    w_state_nx = (bus == OP_HLT) ? HALT : RUN;
                end
                T2: w_cycle_nx = w_opnd ? T3 : T0;
                T3: begin
                    c_ro       = 1'b1;
                    w_cycle_nx = w_mem_op ? T4 : T0;
                end
                T4: begin
                    c_ro = (r_opcode != OP_STA);
                    c_ri = (r_opcode == OP_STA);
                end
                default: w_cycle_nx = T0;
            endcase
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc      <= RESET_PC;
            r_opcode  <= 8'h00;
            r_rega    <= 8'h00;
            r_regb    <= 8'h00;
            r_mar     <= 8'h00;
            r_eq_zero <= 1'b0;
            r_c_sub   <= 1'b0;
        end else if (r_state == RUN) begin
            case (r_cycle)
                T0: r_mar <= r_pc;
                T1: begin
                    r_opcode <= bus;
                    r_pc     <= r_pc + 8'd1;
                    if (w_alu_op) r_c_sub <= (bus == OP_SUB);
                end
                T2: begin
                    if (w_opnd) r_mar <= r_pc;
                    else if (w_alu_op) begin
                        r_rega    <= w_alu_out;
                        r_eq_zero <= (w_alu_out == 8'h00);
                    end
                end
                T3: begin
                    if (r_opcode == OP_LDI) r_rega <= bus;
                    if (w_mem_op) r_mar <= bus;
                    r_pc <= ((r_opcode == OP_JMP) || (r_opcode == OP_JZ && r_eq_zero) || (w_jc_op && w_carry))
                            ? bus : r_pc + 8'd1;
                end
                T4: begin
                    if (r_opcode == OP_LDA) r_rega <= bus;
                    if (r_opcode == OP_LDB) r_regb <= bus;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu.sv
// tb_cpu: table-driven program runs against a behavioural RAM, with a scoreboard of expected memory writes.
module tb_cpu;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    wire  [7:0] bus;
    logic [7:0] addr_bus;
    logic       mem_clk, c_ri, c_ro;
    cpu dut (.clk(clk), .reset(reset), .addr_bus(addr_bus), .bus(bus), .mem_clk(mem_clk), .c_ri(c_ri), .c_ro(c_ro));
    always #5 clk = ~clk;
    // RAM = preload image overlaid by writes tagged with the current run's generation.
    logic [7:0] init_mem [256];
    logic [7:0] wr_mem   [256];
    int         wr_gen   [256];
    int         gen = 0;
    logic [7:0] w_rd;
    always_comb w_rd = (wr_gen[addr_bus] == gen) ? wr_mem[addr_bus] : init_mem[addr_bus];
    assign bus = c_ro ? w_rd : 8'hzz;
    int n_chk = 0, n_pass = 0;
    logic [15:0] exp_q [$];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask
    always @(posedge mem_clk) begin
        if (c_ri) begin
            wr_mem[addr_bus] = bus;
            wr_gen[addr_bus] = gen;
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_write: got %0h expected none", {addr_bus, bus});
            end else chk("mem_write", {16'h0, addr_bus, bus}, {16'h0, exp_q.pop_front()});
        end
    end
    function automatic logic [7:0] mem_rd(input logic [7:0] a);
        return (wr_gen[a] == gen) ? wr_mem[a] : init_mem[a];
    endfunction
    task automatic load(input logic [127:0] p);
        gen++;
        for (int i = 0; i < 256; i++) init_mem[i] = 8'h09;
        for (int i = 0; i < 16; i++) init_mem[i] = p[127-8*i -: 8];
    endtask
    task automatic start(input logic [127:0] p, input logic wv, input logic [15:0] w);
        reset = 1'b0;
        load(p);
        if (wv) exp_q.push_back(w);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
    endtask
    task automatic run_halt(input string nm);
        int k = 0;
        while (dut.r_state == 1'b0 && k < 300) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (k >= 300) begin
            n_chk++;
            $display("FAIL %s_timeout: got running expected HALT", nm);
        end
    endtask
    typedef struct {
        logic [127:0] prog;
        logic         wv;
        logic [15:0]  wr;
        logic [7:0]   rega, regb, pc;
        logic         z;
    } vec_t;
    vec_t vecs [8];
    initial begin
        logic [7:0] pc_hold;
        int         bad;
        vecs[0] = '{128'h01050320_04200509_09090909_09090909, 1'b1, 16'h2005, 8'h0A, 8'h05, 8'h08, 1'b0};
        vecs[1] = '{128'h01030320_04200608_40090909_09090909, 1'b1, 16'h2003, 8'h00, 8'h03, 8'h41, 1'b1};
        vecs[2] = '{128'h01020321_04210103_06084009_09090909, 1'b1, 16'h2102, 8'h01, 8'h02, 8'h0C, 1'b0};
        vecs[3] = '{128'h01010320_042001FF_05090909_09090909, 1'b1, 16'h2001, 8'h00, 8'h01, 8'h0A, 1'b1};
        vecs[4] = '{128'hEE090909_09090909_09090909_09090909, 1'b0, 16'h0000, 8'h00, 8'h00, 8'h02, 1'b0};
        vecs[5] = '{128'h00010709_09090909_09090909_09090909, 1'b0, 16'h0000, 8'h07, 8'h00, 8'h04, 1'b0};
`ifdef CPU_CARRY_FLAG_EN
        vecs[6] = '{128'h01010320_042001FF_050A3009_09090909, 1'b1, 16'h2001, 8'h00, 8'h01, 8'h31, 1'b1};
`else
        vecs[6] = '{128'h01010320_042001FF_050A3009_09090909, 1'b1, 16'h2001, 8'h00, 8'h01, 8'h0C, 1'b1};
`endif
        vecs[7] = '{128'h015A0330_01000230_04300509_09090909, 1'b1, 16'h305A, 8'hB4, 8'h5A, 8'h0C, 1'b0};
        // reset state
        load(128'h0);
        #1;
        chk("rst_pc", {24'h0, dut.r_pc}, 32'h00);
        chk("rst_cycle", {29'h0, dut.r_cycle}, 32'h0);
        chk("rst_regs", {8'h0, dut.r_rega, dut.r_regb, addr_bus}, 32'h0);
        chk("rst_flags_ctl", {29'h0, dut.r_eq_zero, c_ri, c_ro}, 32'h0);
        for (int v = 0; v < 8; v++) begin
            start(vecs[v].prog, vecs[v].wv, vecs[v].wr);
            run_halt($sformatf("vec%0d", v));
            chk($sformatf("vec%0d_rega", v), {24'h0, dut.r_rega}, {24'h0, vecs[v].rega});
            chk($sformatf("vec%0d_regb", v), {24'h0, dut.r_regb}, {24'h0, vecs[v].regb});
            chk($sformatf("vec%0d_pc", v), {24'h0, dut.r_pc}, {24'h0, vecs[v].pc});
            chk($sformatf("vec%0d_eqz", v), {31'h0, dut.r_eq_zero}, {31'h0, vecs[v].z});
        end
        // JMP FF: LDI at FF takes its operand from wrapped address 00
        start(128'h07FF0909_09090909_09090909_09090909, 1'b0, 16'h0);
        init_mem[8'hFF] = 8'h01;
        run_halt("wrap");
        chk("wrap_rega", {24'h0, dut.r_rega}, 32'h07);
        chk("wrap_pc", {24'h0, dut.r_pc}, 32'h03);
        // undefined opcode finishes in two clocks
        start(128'hEE090909_09090909_09090909_09090909, 1'b0, 16'h0);
        @(posedge clk) #1;
        chk("ee_t1_fetch", {23'h0, c_ro, addr_bus}, {23'h0, 1'b1, 8'h00});
        @(posedge clk) #1;
        chk("ee_back_t0", {21'h0, dut.r_cycle, dut.r_pc}, {21'h0, 3'd0, 8'h01});
        // reset during STA T3 aborts without a memory write
        start(128'h01050320_09090909_09090909_09090909, 1'b0, 16'h0);
        repeat (7) @(posedge clk);
        #1;
        chk("sta_in_t3", {29'h0, dut.r_cycle}, 32'h3);
        reset = 1'b0;
        #1;
        chk("abort_pc_cycle", {21'h0, dut.r_cycle, dut.r_pc}, 32'h0);
        chk("abort_ctl", {30'h0, c_ri, c_ro}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_mem20", {24'h0, mem_rd(8'h20)}, 32'h09);
        exp_q.push_back(16'h2005);
        @(negedge clk) reset = 1'b1;
        run_halt("resume");
        chk("resume_rega_pc", {16'h0, dut.r_rega, dut.r_pc}, {16'h0, 8'h05, 8'h05});
        pc_hold = dut.r_pc;
        bad = 0;
        repeat (100) begin
            @(posedge clk) #1;
            if (c_ri || c_ro || dut.r_pc != pc_hold || dut.r_state == 1'b0) bad++;
        end
        chk("halt_hold_100", bad, 0);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/cpu.md
CPU -- requirements
Module: cpu

Interface
REQ-001 Parameter: RESET_PC, 8'h00, PC value loaded on reset.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 addr_bus  output  8  memory address, driven from internal MAR register.
REQ-005 bus  inout  8  shared data bus; cpu drives only during store, otherwise high-Z.
REQ-006 mem_clk  output  1  memory clock, equals ~clk.
REQ-007 c_ri  output  1  RAM write enable (RAM captures bus on mem_clk rise).
REQ-008 c_ro  output  1  RAM output enable (RAM drives bus combinationally).

Function
REQ-009 Internal state SHALL be: pc, cycle (3-bit micro-step T0..T4), state (RUN/HALT), opcode, rega, regb, mar, eq_zero, c_sub; alu_out combinational.
REQ-010 alu_out SHALL be rega+regb when c_sub=0 and rega-regb when c_sub=1, modulo 256.
REQ-011 Fetch: T0 mar<=pc; T1 c_ro=1, opcode<=bus, pc<=pc+1.
REQ-012 Operand fetch (opcodes 01,02,03,04,07,08): T2 mar<=pc; T3 c_ro=1, operand sampled from bus.
REQ-013 01 LDI: T3 rega<=bus, pc++; done.
REQ-014 02 LDA / 04 LDB: T3 mar<=bus, pc++; T4 c_ro=1, rega (LDA) or regb (LDB) <=bus; done.
REQ-015 03 STA: T3 mar<=bus, pc++; T4 c_ri=1, cpu drives bus with rega; done.
REQ-016 05 ADD / 06 SUB: T2 c_sub=0/1, rega<=alu_out, eq_zero<=(alu_out==0); done.
REQ-017 07 JMP: T3 pc<=bus. 08 JZ: T3 pc<=bus if eq_zero, else pc++.
REQ-018 09 HLT: state<=HALT at T1 end; in HALT no register, pc or memory activity until reset.
REQ-019 00 NOP and every undefined opcode SHALL complete after T1.
REQ-020 After an instruction's last step cycle SHALL return to T0 on the next edge.
REQ-021 eq_zero SHALL change only on ADD/SUB (and reset).
REQ-022 pc and mar SHALL wrap 0xFF->0x00; operand fetch at 0xFF reads address 0x00.
REQ-023 c_ri and c_ro SHALL never be 1 simultaneously; both 0 in T0 and in HALT.

Reset
REQ-024 reset low SHALL immediately force pc=RESET_PC, cycle=T0, state=RUN, opcode=rega=regb=mar=0, eq_zero=0, c_sub=0, c_ri=c_ro=0, bus high-Z.
REQ-025 Reset mid-instruction SHALL abort it; no partial memory write occurs.
REQ-026 Execution SHALL resume with fetch at first rising clk after reset release.

Configuration
REQ-027 Macro CPU_CARRY_FLAG_EN: when defined, ADD/SUB also latch carry (ADD carry-out; SUB borrow-free when rega>=regb) and opcode 0A JC addr jumps like JZ on carry; carry resets to 0.
REQ-028 Without CPU_CARRY_FLAG_EN no carry register exists and 0A behaves as NOP.

Verification
REQ-029 Reset mid-run (T3 of STA) -> pc=00, cycle=0, c_ri=c_ro=0 at once; target memory unchanged.
REQ-030 Program 01 05, 03 20, 04 20, 05, 09 -> mem[20]=05, rega=0A, regb=05, pc=08, HALT held 100 clocks.
REQ-031 rega=03, regb=03, SUB then JZ 40 -> rega=00, eq_zero=1, pc=40; with regb=02 -> rega=01, eq_zero=0, pc falls through.
REQ-032 rega=FF, regb=01, ADD -> rega=00, eq_zero=1; JMP FF then fetch at FF -> operand read from 00.
REQ-033 Opcode EE -> completes in 2 clocks, pc+1, no register change.
REQ-034 With CPU_CARRY_FLAG_EN: FF+01 then JC 30 -> pc=30; without macro 0A -> NOP.
